// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: default widths/limits and FSM encodings.
// Imported by the interface, the top and any sibling block that needs them.
package period_meter_pkg;

   localparam int                     PM_WIDTH          = 27;
   localparam logic [PM_WIDTH-1:0]    PM_TIMEOUT_DEF    = 27'd100_000_000;
   localparam logic [PM_WIDTH-1:0]    PM_MIN_PERIOD_DEF = 27'd2;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } pm_state_t;

endpackage

// File: rtl/period_meter_if.sv
// Frame-tick input and measurement results of the period meter, grouped as one bus.
// master = meter side (drives results), slave = consumer side (drives the tick).
interface period_meter_if
   import period_meter_pkg::*;
#(
   parameter int WIDTH = PM_WIDTH
) ();

   logic             fc_clk;
   logic [WIDTH-1:0] tm_value;
   logic             tm_valid;
   logic             timeout;
   logic             measuring;
   logic [7:0]       glitch_cnt;

   modport master (
      input  fc_clk,
      output tm_value, tm_valid, timeout, measuring, glitch_cnt
   );

   modport slave (
      output fc_clk,
      input  tm_value, tm_valid, timeout, measuring, glitch_cnt
   );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector: rise is high in the cycle 'in' first samples high.
// Zero latency from 'in' to 'rise'; no backpressure.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic rise
);

   logic in_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_d <= 1'b0;
      end else begin
         in_d <= in;
      end
   end

   assign rise = in & ~in_d;

endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between accepted fc_clk rising edges; rejects short glitches, flags timeouts.
// Result appears one cycle after the closing edge; no backpressure (tm_valid is a bare pulse).
module period_meter
   import period_meter_pkg::*;
#(
   parameter int               WIDTH      = PM_WIDTH,
   parameter logic [WIDTH-1:0] TIMEOUT    = WIDTH'(PM_TIMEOUT_DEF),
   parameter logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(PM_MIN_PERIOD_DEF)
) (
   input  logic           clk,
   input  logic           rst,
   period_meter_if.master pm
);

   pm_state_t        state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tm_value_q, tm_value_d;
   logic             tm_valid_q, tm_valid_d;
   logic             timeout_q, timeout_d;
   logic [7:0]       glitch_q, glitch_d;
   logic             rise;

   edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .in   (pm.fc_clk),
      .rise (rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tm_value_q <= '0;
         tm_valid_q <= 1'b0;
         timeout_q  <= 1'b0;
         glitch_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tm_value_q <= tm_value_d;
         tm_valid_q <= tm_valid_d;
         timeout_q  <= timeout_d;
         glitch_q   <= glitch_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tm_value_d = tm_value_q;
      tm_valid_d = 1'b0;
      timeout_d  = timeout_q;
      glitch_d   = glitch_q;
      case (state_q)
         IDLE: begin
            // The first edge only establishes the reference; timeout stays sticky.
            if (rise) begin
               state_d = MEASURE;
               cnt_d   = WIDTH'(1);
            end
         end
         MEASURE: begin
            if (rise && (cnt_q >= MIN_PERIOD)) begin
               tm_value_d = cnt_q;
               tm_valid_d = 1'b1;
               timeout_d  = 1'b0;
               cnt_d      = WIDTH'(1);
            end else if (rise) begin
               glitch_d = glitch_q + 8'd1;
               cnt_d    = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + WIDTH'(1);
            end else if (cnt_q == TIMEOUT) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pm.tm_value   = tm_value_q;
   assign pm.tm_valid   = tm_valid_q;
   assign pm.timeout    = timeout_q;
   assign pm.measuring  = (state_q == MEASURE);
   assign pm.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: three instances with different limits, an edge-timestamp model, directed stimulus.
module tb_period_meter;

   logic       clk;
   logic [2:0] rst;
   logic [2:0] fc;
   longint     cyc;
   int         checks;
   int         failures;

   period_meter_if #(.WIDTH(27)) if_a ();
   period_meter_if #(.WIDTH(27)) if_b ();
   period_meter_if #(.WIDTH(27)) if_c ();

   assign if_a.fc_clk = fc[0];
   assign if_b.fc_clk = fc[1];
   assign if_c.fc_clk = fc[2];

   period_meter #(.WIDTH(27)) dut_a (.clk(clk), .rst(rst[0]), .pm(if_a));
   period_meter #(.WIDTH(27), .TIMEOUT(27'd100), .MIN_PERIOD(27'd4)) dut_b (.clk(clk), .rst(rst[1]), .pm(if_b));
   period_meter #(.WIDTH(27), .MIN_PERIOD(27'd600)) dut_c (.clk(clk), .rst(rst[2]), .pm(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: remember when the reference edge was seen; every outcome follows from edge spacing.
   typedef struct {
      logic        prev;
      bit          in_meas;
      longint      ref_t;
      logic [26:0] tmval;
      bit          tmv;
      bit          to;
      int          gl;
   } mdl_t;

   mdl_t   m [3];
   longint min_p [3] = '{2, 4, 600};
   longint tout  [3] = '{100_000_000, 100, 100_000_000};

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int id = 0; id < 3; id++) begin
         if (rst[id]) begin
            m[id].prev = 1'b0; m[id].in_meas = 0; m[id].ref_t = 0;
            m[id].tmval = '0; m[id].tmv = 0; m[id].to = 0; m[id].gl = 0;
         end else begin
            logic   e;
            longint gap;
            e = fc[id] & ~m[id].prev;
            m[id].prev = fc[id];
            m[id].tmv = 0;
            gap = cyc - m[id].ref_t;
            if (e) begin
               if (!m[id].in_meas) begin
                  m[id].in_meas = 1;
                  m[id].ref_t = cyc;
               end else if (gap < min_p[id]) begin
                  m[id].gl = (m[id].gl + 1) % 256;
               end else begin
                  m[id].tmval = 27'(gap);
                  m[id].tmv = 1;
                  m[id].to = 0;
                  m[id].ref_t = cyc;
               end
            end else if (m[id].in_meas && gap == tout[id]) begin
               m[id].in_meas = 0;
               m[id].to = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic cmp_dut(input int id, input logic [26:0] v, input logic vl, input logic to,
                          input logic ms, input logic [7:0] g);
      chk($sformatf("dut%0d_tm_value", id), 64'(v), 64'(m[id].tmval));
      chk($sformatf("dut%0d_tm_valid", id), 64'(vl), 64'(m[id].tmv));
      chk($sformatf("dut%0d_timeout", id), 64'(to), 64'(m[id].to));
      chk($sformatf("dut%0d_measuring", id), 64'(ms), 64'(m[id].in_meas));
      chk($sformatf("dut%0d_glitch_cnt", id), 64'(g), 64'(m[id].gl[7:0]));
   endtask

   always @(negedge clk) begin
      if (cyc > 0) begin
         cmp_dut(0, if_a.tm_value, if_a.tm_valid, if_a.timeout, if_a.measuring, if_a.glitch_cnt);
         cmp_dut(1, if_b.tm_value, if_b.tm_valid, if_b.timeout, if_b.measuring, if_b.glitch_cnt);
         cmp_dut(2, if_c.tm_value, if_c.tm_valid, if_c.timeout, if_c.measuring, if_c.glitch_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Rising edge sampled exactly 'gap' cycles after the previous edge sample.
   task automatic edge_at(input int id, input int gap);
      fc[id] = 1'b0;
      repeat (gap - 1) step();
      fc[id] = 1'b1;
      step();
   endtask

   task automatic idle(input int id, input int n);
      fc[id] = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      cyc = 0; checks = 0; failures = 0;
      rst = 3'b111;
      fc  = 3'b000;
      repeat (3) step();
      chk("rst_a_value", 64'(if_a.tm_value), 64'd0);
      chk("rst_a_meas", 64'(if_a.measuring), 64'd0);
      chk("rst_b_timeout", 64'(if_b.timeout), 64'd0);
      chk("rst_c_glitch", 64'(if_c.glitch_cnt), 64'd0);
      rst = 3'b000;

      // Steady 2000-cycle period
      edge_at(0, 5);
      chk("a_ref_meas", 64'(if_a.measuring), 64'd1);
      chk("a_ref_valid", 64'(if_a.tm_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         edge_at(0, 2000);
         chk("a_2000_valid", 64'(if_a.tm_valid), 64'd1);
         chk("a_2000_value", 64'(if_a.tm_value), 64'd2000);
      end

      // Reset 500 cycles into a period
      idle(0, 500);
      rst[0] = 1'b1;
      step();
      chk("a_rst_value", 64'(if_a.tm_value), 64'd0);
      chk("a_rst_meas", 64'(if_a.measuring), 64'd0);
      rst[0] = 1'b0;
      edge_at(0, 10);
      chk("a_post_rst_meas", 64'(if_a.measuring), 64'd1);
      chk("a_post_rst_valid", 64'(if_a.tm_valid), 64'd0);
      edge_at(0, 2000);
      chk("a_post_rst_value", 64'(if_a.tm_value), 64'd2000);
      chk("a_post_rst_valid2", 64'(if_a.tm_valid), 64'd1);

      // Glitch then accepted edge 10 cycles after reference (MIN_PERIOD 4)
      edge_at(1, 10);
      edge_at(1, 2);
      chk("b_glitch_cnt", 64'(if_b.glitch_cnt), 64'd1);
      chk("b_glitch_valid", 64'(if_b.tm_valid), 64'd0);
      edge_at(1, 8);
      chk("b_after_glitch_value", 64'(if_b.tm_value), 64'd10);
      chk("b_after_glitch_valid", 64'(if_b.tm_valid), 64'd1);
      chk("b_after_glitch_cnt", 64'(if_b.glitch_cnt), 64'd1);

      // Timeout boundary (TIMEOUT 100)
      idle(1, 99);
      chk("b_pre_to_timeout", 64'(if_b.timeout), 64'd0);
      chk("b_pre_to_meas", 64'(if_b.measuring), 64'd1);
      idle(1, 1);
      chk("b_to_timeout", 64'(if_b.timeout), 64'd1);
      chk("b_to_meas", 64'(if_b.measuring), 64'd0);
      chk("b_to_value", 64'(if_b.tm_value), 64'd10);
      edge_at(1, 20);
      chk("b_to_sticky", 64'(if_b.timeout), 64'd1);
      chk("b_to_ref_meas", 64'(if_b.measuring), 64'd1);
      edge_at(1, 50);
      chk("b_50_value", 64'(if_b.tm_value), 64'd50);
      chk("b_50_timeout", 64'(if_b.timeout), 64'd0);
      edge_at(1, 100);
      chk("b_100_value", 64'(if_b.tm_value), 64'd100);
      chk("b_100_valid", 64'(if_b.tm_valid), 64'd1);
      chk("b_100_timeout", 64'(if_b.timeout), 64'd0);

      // Constant-high input: no edges, so it times out
      repeat (150) step();
      chk("b_const_meas", 64'(if_b.measuring), 64'd0);
      chk("b_const_timeout", 64'(if_b.timeout), 64'd1);
      chk("b_const_value", 64'(if_b.tm_value), 64'd100);

      // 256 glitches wrap the counter (MIN_PERIOD 600)
      edge_at(2, 5);
      edge_at(2, 700);
      chk("c_700_value", 64'(if_c.tm_value), 64'd700);
      for (int i = 0; i < 256; i++) begin
         edge_at(2, 2);
         if (i == 254) chk("c_glitch_255", 64'(if_c.glitch_cnt), 64'd255);
      end
      chk("c_glitch_wrap", 64'(if_c.glitch_cnt), 64'd0);
      chk("c_glitch_value", 64'(if_c.tm_value), 64'd700);
      chk("c_glitch_meas", 64'(if_c.measuring), 64'd1);

      // fc_clk already high in the first cycle after reset counts as an edge
      rst[2] = 1'b1;
      step();
      rst[2] = 1'b0;
      step();
      chk("c_post_rst_edge", 64'(if_c.measuring), 64'd1);
      chk("c_post_rst_valid", 64'(if_c.tm_valid), 64'd0);

      idle(0, 5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
